// File: rtl/regfile_commit_queue.sv
// Commit queue between the ROB and the register-file write port.
// Buffers committed {regidx, alias, data} results and writes at most one per cycle.
// Queued entries are committed state: rollback stalls the drain but never flushes it.
module regfile_commit_queue #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned REG_W  = 5,
   parameter int unsigned ROB_W  = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     rdy,
   input  logic                     rollback_signal,
   input  logic                     commit_valid,
   input  logic [REG_W-1:0]         commit_regidx,
   input  logic [ROB_W-1:0]         commit_alias,
   input  logic [DATA_W-1:0]        commit_data,
   output logic                     commit_ready,
   output logic                     rob_has_res,
   output logic [REG_W-1:0]         regidx_from_rob,
   output logic [ROB_W-1:0]         regalias_from_rob,
   output logic [DATA_W-1:0]        result_from_rob,
   input  logic [REG_W-1:0]         query_reg,
   output logic                     query_pending,
   output logic [$clog2(DEPTH):0]   occupancy
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   logic [REG_W-1:0]  regidx_q [DEPTH];
   logic [REG_W-1:0]  regidx_d [DEPTH];
   logic [ROB_W-1:0]  alias_q  [DEPTH];
   logic [ROB_W-1:0]  alias_d  [DEPTH];
   logic [DATA_W-1:0] data_q   [DEPTH];
   logic [DATA_W-1:0] data_d   [DEPTH];
   logic [DEPTH-1:0]  valid_q;
   logic [DEPTH-1:0]  valid_d;
   logic [PTR_W-1:0]  wr_ptr_q;
   logic [PTR_W-1:0]  wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q;
   logic [PTR_W-1:0]  rd_ptr_d;
   logic [CNT_W-1:0]  count_q;
   logic [CNT_W-1:0]  count_d;

   logic push;
   logic pop;
   logic empty;

   // Handshake, write strobe and push/pop qualification
   always_comb begin
      empty        = (count_q == '0);
      commit_ready = (count_q < CNT_W'(DEPTH));
      rob_has_res  = !empty && rdy && !rollback_signal;
      // Register 0 offers complete the handshake but are dropped
      push         = rdy && commit_valid && commit_ready && (commit_regidx != '0);
      pop          = rob_has_res;
      occupancy    = count_q;
   end

   // Head entry drives the write port, zeroed when empty
   always_comb begin
      regidx_from_rob   = '0;
      regalias_from_rob = '0;
      result_from_rob   = '0;
      if (!empty) begin
         regidx_from_rob   = regidx_q[rd_ptr_q];
         regalias_from_rob = alias_q[rd_ptr_q];
         result_from_rob   = data_q[rd_ptr_q];
      end
   end

   // Scoreboard probe: any live entry targeting query_reg
   always_comb begin
      query_pending = 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (valid_q[i] && (regidx_q[i] == query_reg) && (query_reg != '0)) begin
            query_pending = 1'b1;
         end
      end
   end

   // Next-state for storage, pointers and count
   always_comb begin
      regidx_d = regidx_q;
      alias_d  = alias_q;
      data_d   = data_q;
      valid_d  = valid_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         regidx_d[wr_ptr_q] = commit_regidx;
         alias_d[wr_ptr_q]  = commit_alias;
         data_d[wr_ptr_q]   = commit_data;
         valid_d[wr_ptr_q]  = 1'b1;
         wr_ptr_d           = wr_ptr_q + PTR_W'(1);
      end
      // Push never targets the head slot while popping: full blocks push, empty blocks pop
      if (pop) begin
         valid_d[rd_ptr_q] = 1'b0;
         rd_ptr_d          = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
   end

   // State registers with asynchronous clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            regidx_q[i] <= '0;
            alias_q[i]  <= '0;
            data_q[i]   <= '0;
         end
         valid_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         regidx_q <= regidx_d;
         alias_q  <= alias_d;
         data_q   <= data_d;
         valid_q  <= valid_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: tb/tb_regfile_commit_queue.sv
// Directed bench for regfile_commit_queue (default parameters: DEPTH=4, DATA_W=32).
// Inputs change 1 time unit after a rising edge; outputs are checked 1 unit later.
module tb_regfile_commit_queue;

   logic        clk;
   logic        rst;
   logic        rdy;
   logic        rollback_signal;
   logic        commit_valid;
   logic [4:0]  commit_regidx;
   logic [3:0]  commit_alias;
   logic [31:0] commit_data;
   logic        commit_ready;
   logic        rob_has_res;
   logic [4:0]  regidx_from_rob;
   logic [3:0]  regalias_from_rob;
   logic [31:0] result_from_rob;
   logic [4:0]  query_reg;
   logic        query_pending;
   logic [2:0]  occupancy;

   int n_checks;
   int n_errors;

   regfile_commit_queue dut (
      .clk               (clk),
      .rst               (rst),
      .rdy               (rdy),
      .rollback_signal   (rollback_signal),
      .commit_valid      (commit_valid),
      .commit_regidx     (commit_regidx),
      .commit_alias      (commit_alias),
      .commit_data       (commit_data),
      .commit_ready      (commit_ready),
      .rob_has_res       (rob_has_res),
      .regidx_from_rob   (regidx_from_rob),
      .regalias_from_rob (regalias_from_rob),
      .result_from_rob   (result_from_rob),
      .query_reg         (query_reg),
      .query_pending     (query_pending),
      .occupancy         (occupancy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [4:0] r, input logic [3:0] a, input logic [31:0] d);
      commit_valid  = 1'b1;
      commit_regidx = r;
      commit_alias  = a;
      commit_data   = d;
   endtask

   // Watchdog so a stuck run still terminates
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      int n_out;
      int max_occ;

      n_checks = 0;
      n_errors = 0;
      rst = 1'b1;
      rdy = 1'b1;
      rollback_signal = 1'b0;
      commit_valid = 1'b0;
      commit_regidx = '0;
      commit_alias = '0;
      commit_data = '0;
      query_reg = '0;

      // Reset state
      #2;
      check("rst_occ",   64'(occupancy), 64'd0);
      check("rst_ready", 64'(commit_ready), 64'd1);
      check("rst_wr",    64'(rob_has_res), 64'd0);
      check("rst_data",  64'(result_from_rob), 64'd0);
      check("rst_qp",    64'(query_pending), 64'd0);
      tick();
      rst = 1'b0;

      // Single commit
      offer(5'd5, 4'd3, 32'hDEADBEEF);
      tick();
      commit_valid = 1'b0;
      #1;
      check("single_wr",    64'(rob_has_res), 64'd1);
      check("single_reg",   64'(regidx_from_rob), 64'd5);
      check("single_alias", 64'(regalias_from_rob), 64'd3);
      check("single_data",  64'(result_from_rob), 64'hDEADBEEF);
      check("single_occ1",  64'(occupancy), 64'd1);
      tick();
      check("single_occ0",  64'(occupancy), 64'd0);
      check("single_wr0",   64'(rob_has_res), 64'd0);
      check("single_zero",  64'(regidx_from_rob), 64'd0);

      // Fill under rollback, then drain in order
      rollback_signal = 1'b1;
      for (int i = 0; i < 5; i++) begin
         offer(5'(i + 1), 4'(i), 32'h100 + 32'(i));
         #1;
         check("fill_ready", 64'(commit_ready), (i < 4) ? 64'd1 : 64'd0);
         check("fill_hold",  64'(rob_has_res), 64'd0);
         tick();
      end
      commit_valid = 1'b0;
      #1;
      check("fill_occ", 64'(occupancy), 64'd4);
      rollback_signal = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("drain_wr",   64'(rob_has_res), 64'd1);
         check("drain_data", 64'(result_from_rob), 64'h100 + 64'(i));
         check("drain_reg",  64'(regidx_from_rob), 64'(i + 1));
         tick();
      end
      check("drain_occ", 64'(occupancy), 64'd0);

      // Rollback holds the head for two cycles
      offer(5'd10, 4'd2, 32'h2A);
      tick();
      commit_valid = 1'b0;
      rollback_signal = 1'b1;
      #1;
      check("rb_hold1", 64'(rob_has_res), 64'd0);
      check("rb_occ1",  64'(occupancy), 64'd1);
      tick();
      check("rb_hold2", 64'(rob_has_res), 64'd0);
      check("rb_occ2",  64'(occupancy), 64'd1);
      tick();
      rollback_signal = 1'b0;
      #1;
      check("rb_wr",   64'(rob_has_res), 64'd1);
      check("rb_reg",  64'(regidx_from_rob), 64'd10);
      check("rb_data", 64'(result_from_rob), 64'h2A);
      tick();
      check("rb_occ0", 64'(occupancy), 64'd0);

      // x0 discard and register query
      rollback_signal = 1'b1;
      query_reg = 5'd7;
      offer(5'd0, 4'd1, 32'h99);
      #1;
      check("x0_ready", 64'(commit_ready), 64'd1);
      tick();
      check("x0_occ", 64'(occupancy), 64'd0);
      check("x0_qp",  64'(query_pending), 64'd0);
      offer(5'd7, 4'd5, 32'h77);
      tick();
      commit_valid = 1'b0;
      #1;
      check("q_occ",  64'(occupancy), 64'd1);
      check("q_pend", 64'(query_pending), 64'd1);
      query_reg = 5'd0;
      #1;
      check("q_zero", 64'(query_pending), 64'd0);
      query_reg = 5'd7;
      rollback_signal = 1'b0;
      #1;
      check("q_head",  64'(query_pending), 64'd1);
      check("q_wr",    64'(rob_has_res), 64'd1);
      check("q_reg",   64'(regidx_from_rob), 64'd7);
      tick();
      check("q_clear", 64'(query_pending), 64'd0);
      check("q_occ0",  64'(occupancy), 64'd0);
      query_reg = 5'd0;

      // rdy low freezes the queue
      offer(5'd3, 4'd6, 32'h33);
      tick();
      rdy = 1'b0;
      offer(5'd4, 4'd7, 32'h44);
      #1;
      check("frz_wr", 64'(rob_has_res), 64'd0);
      tick();
      check("frz_occ", 64'(occupancy), 64'd1);
      check("frz_wr2", 64'(rob_has_res), 64'd0);
      commit_valid = 1'b0;
      rdy = 1'b1;
      #1;
      check("frz_wr3",  64'(rob_has_res), 64'd1);
      check("frz_data", 64'(result_from_rob), 64'h33);
      tick();
      check("frz_occ0", 64'(occupancy), 64'd0);

      // Same register twice: both written, later value last
      offer(5'd9, 4'd1, 32'hA1);
      tick();
      offer(5'd9, 4'd2, 32'hA2);
      #1;
      check("dup_first", 64'(result_from_rob), 64'hA1);
      tick();
      commit_valid = 1'b0;
      #1;
      check("dup_second", 64'(result_from_rob), 64'hA2);
      check("dup_reg",    64'(regidx_from_rob), 64'd9);
      tick();
      check("dup_occ0", 64'(occupancy), 64'd0);

      // Wrap: 10 commits with overlapping push/pop, bursty pushes
      k = 0;
      n_out = 0;
      max_occ = 0;
      for (int c = 0; c < 40 && n_out < 10; c++) begin
         if (k < 10 && (c % 3) != 2) begin
            offer(5'(k % 31 + 1), 4'(k), 32'h200 + 32'(k));
         end else begin
            commit_valid = 1'b0;
         end
         rollback_signal = (c % 5) == 1;
         #1;
         if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
         if (rob_has_res) begin
            check("wrap_data", 64'(result_from_rob), 64'h200 + 64'(n_out));
            n_out++;
         end
         if (commit_valid && commit_ready) k++;
         tick();
      end
      commit_valid = 1'b0;
      rollback_signal = 1'b0;
      check("wrap_count", 64'(n_out), 64'd10);
      check("wrap_maxok", 64'(max_occ <= 4), 64'd1);

      // Async reset mid-drain
      rollback_signal = 1'b1;
      for (int i = 0; i < 3; i++) begin
         offer(5'(20 + i), 4'(i), 32'h300 + 32'(i));
         tick();
      end
      commit_valid = 1'b0;
      rollback_signal = 1'b0;
      query_reg = 5'd22;
      #1;
      check("ar_occ3", 64'(occupancy), 64'd3);
      check("ar_qp",   64'(query_pending), 64'd1);
      tick();
      check("ar_occ2", 64'(occupancy), 64'd2);
      rst = 1'b1;
      #1;
      check("ar_occ",  64'(occupancy), 64'd0);
      check("ar_wr",   64'(rob_has_res), 64'd0);
      check("ar_data", 64'(result_from_rob), 64'd0);
      check("ar_qp0",  64'(query_pending), 64'd0);
      check("ar_rdy",  64'(commit_ready), 64'd1);
      tick();
      rst = 1'b0;
      #1;
      check("ar_post_wr", 64'(rob_has_res), 64'd0);
      tick();
      check("ar_post_wr2", 64'(rob_has_res), 64'd0);
      check("ar_post_occ", 64'(occupancy), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
